control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clock, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port ir, input, 32: current instruction; opcode ir[31:27].
REQ-004 SHALL have port mem_ready, input, 1: memory has completed the requested read/write this cycle.
REQ-005 SHALL have port con_ff, input, 1: branch condition result.
REQ-006 SHALL have port stop, input, 1: halt request, honoured at instruction boundary.
REQ-007 SHALL have ports Gra, Grb, Grc, Rin, Rout, BAout, Cout, output, 1 each: register-select controls to the select/encode stage.
REQ-008 SHALL have ports PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, CONin, Read, Write, output, 1 each: datapath strobes.
REQ-009 SHALL have port alu_op, output, 4: ADD=0000, SUB=0001, AND=0010, OR=0011.
REQ-010 SHALL have ports run (1 = executing) and illegal (1-cycle pulse on unknown opcode), output, 1 each.

Function
REQ-011 SHALL be a Moore FSM; outputs are decoded from registered state and ir only; all unlisted outputs are 0 in each state.
REQ-012 SHALL support opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, br 10010, nop 11010, halt 11011.
REQ-013 SHALL have states T0..T7 and HALT.
REQ-014 SHALL perform fetch for every instruction:
- T0: PCout, MARin, IncPC, Zin
- T1: Zlowout, PCin, Read, MDRin
- T2: MDRout, IRin
REQ-015 SHALL execute ld as:
- T3: Grb, BAout, Yin
- T4: Cout, alu_op=ADD, Zin
- T5: Zlowout, MARin
- T6: Read, MDRin
- T7: MDRout, Gra, Rin
REQ-016 SHALL execute ldi as ld T3-T4, then T5: Zlowout, Gra, Rin.
REQ-017 SHALL execute st as ld T3-T5, then:
- T6: Gra, Rout, MDRin
- T7: Write
REQ-018 SHALL execute add/sub/and/or as:
- T3: Grb, Rout, Yin
- T4: Grc, Rout, alu_op per opcode, Zin
- T5: Zlowout, Gra, Rin
REQ-019 SHALL execute addi as T3: Grb, Rout, Yin; T4: Cout, ADD, Zin; T5: Zlowout, Gra, Rin.
REQ-020 SHALL execute br as:
- T3: Gra, Rout, CONin
- T4: PCout, Yin
- T5: Cout, ADD, Zin
- T6: Zlowout and PCin only if con_ff=1
REQ-021 SHALL hold the state (outputs unchanged) in T1, ld-T6 and st-T7 while mem_ready=0, advancing on the first cycle mem_ready=1.
REQ-022 SHALL treat nop, and any unlisted opcode, as complete after T2; an unlisted opcode SHALL pulse illegal in T2.
REQ-023 SHALL enter HALT after T2 of halt; in HALT all strobes are 0 and run=0 until reset.
REQ-024 SHALL go to HALT instead of T0 when stop=1 in the final cycle of an instruction; stop is ignored mid-instruction.
REQ-025 SHALL NOT assert Read and Write together, or Rin together with Rout/BAout.

Reset
REQ-026 SHALL, in any cycle with reset=1, drive all outputs 0 except run=1, and enter T0 next cycle.
REQ-027 SHALL abort an in-progress instruction on reset, including during a mem_ready stall, with no further strobes for it.

Structure
REQ-028 SHALL take opcode constants, the state enumeration and alu_op encodings from shared package cpu_ctrl_pkg.
REQ-029 SHALL split into a sequential state register/next-state block and one combinational sub-module, control_outputs (state, ir, con_ff to strobes).

Verification
REQ-030 SHALL cover: ir=0x08800005 (ldi R1,5(R0)), mem_ready=1 -> T3 Grb/BAout/Yin; T5 Gra/Rin; T0 again at cycle 6.
REQ-031 SHALL cover: ir=0x19890000 (add R3,R1,R2) -> T3 Grb/Rout; T4 Grc/Rout/alu_op=0000; T5 Gra/Rin.
REQ-032 SHALL cover: mem_ready=0 for 3 cycles in T1 -> Read/MDRin high 4 cycles, then T2.
REQ-033 SHALL cover: br with con_ff=0 -> T6 has PCin=0 and Zlowout=0; with con_ff=1 -> both 1.
REQ-034 SHALL cover: opcode 11011 -> run=0 from cycle after T2, strobes 0 for 20 cycles; reset -> T0.
REQ-035 SHALL cover: reset during ld T5 -> reset cycle all strobes 0; next cycle T0 strobes.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired control unit: opcodes, ALU selects, FSM states
// and the bundled control word driven by the output decoder.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

  typedef struct packed {
    logic       gra;
    logic       grb;
    logic       grc;
    logic       rin;
    logic       rout;
    logic       ba_out;
    logic       c_out;
    logic       pc_out;
    logic       pc_in;
    logic       inc_pc;
    logic       mar_in;
    logic       mdr_in;
    logic       mdr_out;
    logic       ir_in;
    logic       y_in;
    logic       z_in;
    logic       zlow_out;
    logic       con_in;
    logic       read;
    logic       write;
    logic [3:0] alu_op;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_legal(input logic [4:0] op);
    case (op)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI, OP_BR, OP_NOP, OP_HALT: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] alu_sel(input logic [4:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_outputs.sv
// Moore output decoder: maps the current T-state and opcode (plus con_ff for the
// branch commit step) onto the datapath strobes; purely combinational.
module control_outputs
  import cpu_ctrl_pkg::*;
(
  input  state_t      state,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output ctrl_t       ctrl
);

  logic [4:0] op;
  logic       unused_ir_low;

  assign op            = ir[31:27];
  assign unused_ir_low = ^ir[26:0];

  always_comb begin
    ctrl = '0;
    case (state)
      T0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
        ctrl.inc_pc = 1'b1;
        ctrl.z_in   = 1'b1;
      end
      T1: begin
        ctrl.zlow_out = 1'b1;
        ctrl.pc_in    = 1'b1;
        ctrl.read     = 1'b1;
        ctrl.mdr_in   = 1'b1;
      end
      T2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
        ctrl.illegal = !is_legal(op);
      end
      T3: begin
        case (op)
          OP_LD, OP_LDI, OP_ST: begin
            ctrl.grb    = 1'b1;
            ctrl.ba_out = 1'b1;
            ctrl.y_in   = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
            ctrl.grb  = 1'b1;
            ctrl.rout = 1'b1;
            ctrl.y_in = 1'b1;
          end
          OP_BR: begin
            ctrl.gra    = 1'b1;
            ctrl.rout   = 1'b1;
            ctrl.con_in = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        case (op)
          OP_LD, OP_LDI, OP_ST, OP_ADDI: begin
            ctrl.c_out  = 1'b1;
            ctrl.alu_op = ALU_ADD;
            ctrl.z_in   = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            ctrl.grc    = 1'b1;
            ctrl.rout   = 1'b1;
            ctrl.alu_op = alu_sel(op);
            ctrl.z_in   = 1'b1;
          end
          OP_BR: begin
            ctrl.pc_out = 1'b1;
            ctrl.y_in   = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        case (op)
          OP_LD, OP_ST: begin
            ctrl.zlow_out = 1'b1;
            ctrl.mar_in   = 1'b1;
          end
          OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
            ctrl.zlow_out = 1'b1;
            ctrl.gra      = 1'b1;
            ctrl.rin      = 1'b1;
          end
          OP_BR: begin
            ctrl.c_out  = 1'b1;
            ctrl.alu_op = ALU_ADD;
            ctrl.z_in   = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        case (op)
          OP_LD: begin
            ctrl.read   = 1'b1;
            ctrl.mdr_in = 1'b1;
          end
          OP_ST: begin
            ctrl.gra    = 1'b1;
            ctrl.rout   = 1'b1;
            ctrl.mdr_in = 1'b1;
          end
          // Branch target is committed only when the condition held.
          OP_BR: begin
            ctrl.zlow_out = con_ff;
            ctrl.pc_in    = con_ff;
          end
          default: ;
        endcase
      end
      T7: begin
        case (op)
          OP_LD: begin
            ctrl.mdr_out = 1'b1;
            ctrl.gra     = 1'b1;
            ctrl.rin     = 1'b1;
          end
          OP_ST:   ctrl.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: T-state register with memory-stall holds and halt
// handling, feeding the combinational strobe decoder.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  input  logic        con_ff,
  input  logic        stop,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        CONin,
  output logic        Read,
  output logic        Write,
  output logic [3:0]  alu_op,
  output logic        run,
  output logic        illegal
);

  state_t     state;
  state_t     state_next;
  logic       instr_done;
  logic [4:0] op;
  ctrl_t      ctrl;
  ctrl_t      ctrl_out;

  assign op = ir[31:27];

  always_ff @(posedge clock) begin
    if (reset) state <= T0;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    instr_done = 1'b0;
    case (state)
      T0: state_next = T1;
      T1: if (mem_ready) state_next = T2;
      T2: begin
        if (op == OP_HALT)                      state_next = HALT;
        else if (op == OP_NOP || !is_legal(op)) instr_done = 1'b1;
        else                                    state_next = T3;
      end
      T3: state_next = T4;
      T4: state_next = T5;
      T5: begin
        if (op == OP_LD || op == OP_ST || op == OP_BR) state_next = T6;
        else                                           instr_done = 1'b1;
      end
      T6: begin
        if (op == OP_LD) begin
          if (mem_ready) state_next = T7;
        end else if (op == OP_ST) begin
          state_next = T7;
        end else begin
          instr_done = 1'b1;
        end
      end
      T7:      if (op != OP_ST || mem_ready) instr_done = 1'b1;
      HALT:    state_next = HALT;
      default: state_next = T0;
    endcase
    // stop is only looked at on the cycle that actually retires the instruction.
    if (instr_done) state_next = stop ? HALT : T0;
  end

  control_outputs u_outputs (
    .state  (state),
    .ir     (ir),
    .con_ff (con_ff),
    .ctrl   (ctrl)
  );

  assign ctrl_out = reset ? '0 : ctrl;
  assign run      = reset || (state != HALT);

  assign Gra     = ctrl_out.gra;
  assign Grb     = ctrl_out.grb;
  assign Grc     = ctrl_out.grc;
  assign Rin     = ctrl_out.rin;
  assign Rout    = ctrl_out.rout;
  assign BAout   = ctrl_out.ba_out;
  assign Cout    = ctrl_out.c_out;
  assign PCout   = ctrl_out.pc_out;
  assign PCin    = ctrl_out.pc_in;
  assign IncPC   = ctrl_out.inc_pc;
  assign MARin   = ctrl_out.mar_in;
  assign MDRin   = ctrl_out.mdr_in;
  assign MDRout  = ctrl_out.mdr_out;
  assign IRin    = ctrl_out.ir_in;
  assign Yin     = ctrl_out.y_in;
  assign Zin     = ctrl_out.z_in;
  assign Zlowout = ctrl_out.zlow_out;
  assign CONin   = ctrl_out.con_in;
  assign Read    = ctrl_out.read;
  assign Write   = ctrl_out.write;
  assign alu_op  = ctrl_out.alu_op;
  assign illegal = ctrl_out.illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed per-cycle vector bench for control_sequencer: a table of expected strobes
// per cycle plus hand-written halt and reset-abort sequences.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ir = '0;
  logic        mem_ready = 1'b1;
  logic        con_ff = 1'b0;
  logic        stop = 1'b0;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC, MARin, MDRin;
  logic MDRout, IRin, Yin, Zin, Zlowout, CONin, Read, Write, run, illegal;
  logic [3:0]  alu_op;
  logic [19:0] strobes;

  int tests = 0;
  int fails = 0;

  localparam logic [19:0] GRA = 20'h80000, GRB = 20'h40000, GRC = 20'h20000, RIN = 20'h10000;
  localparam logic [19:0] ROUT = 20'h08000, BAOUT = 20'h04000, COUT = 20'h02000, PCOUT = 20'h01000;
  localparam logic [19:0] PCIN = 20'h00800, INCPC = 20'h00400, MARIN = 20'h00200, MDRIN = 20'h00100;
  localparam logic [19:0] MDROUT = 20'h00080, IRIN = 20'h00040, YIN = 20'h00020, ZIN = 20'h00010;
  localparam logic [19:0] ZLOW = 20'h00008, CONIN = 20'h00004, READ = 20'h00002, WRITE = 20'h00001;
  localparam logic [19:0] F0 = PCOUT | MARIN | INCPC | ZIN;
  localparam logic [19:0] F1 = ZLOW | PCIN | READ | MDRIN;
  localparam logic [19:0] F2 = MDROUT | IRIN;

  localparam logic [31:0] IR_LDI  = 32'h08800005;
  localparam logic [31:0] IR_LD   = 32'h00000000;
  localparam logic [31:0] IR_ST   = 32'h10000000;
  localparam logic [31:0] IR_ADDI = 32'h60000000;
  localparam logic [31:0] IR_BR   = 32'h90000000;
  localparam logic [31:0] IR_NOP  = 32'hD0000000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;
  localparam logic [31:0] IR_BAD  = 32'hF8000000;

  typedef struct {
    logic [63:0] name;
    logic        rst;
    logic [31:0] ir;
    logic        mr;
    logic        cf;
    logic        stp;
    logic [19:0] exp_s;
    logic [3:0]  exp_alu;
    logic        exp_run;
    logic        exp_ill;
  } vec_t;

  vec_t tbl[$];

  control_sequencer dut (
    .clock(clock), .reset(reset), .ir(ir), .mem_ready(mem_ready), .con_ff(con_ff), .stop(stop),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .CONin(CONin), .Read(Read),
    .Write(Write), .alu_op(alu_op), .run(run), .illegal(illegal)
  );

  assign strobes = {Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC, MARin, MDRin,
                    MDRout, IRin, Yin, Zin, Zlowout, CONin, Read, Write};

  always #5 clock = ~clock;

  task automatic add(input logic [63:0] name, input logic rst, input logic [31:0] i,
                     input logic mr, input logic cf, input logic stp, input logic [19:0] s,
                     input logic [3:0] alu, input logic r, input logic ill);
    vec_t v;
    v.name = name; v.rst = rst; v.ir = i; v.mr = mr; v.cf = cf; v.stp = stp;
    v.exp_s = s; v.exp_alu = alu; v.exp_run = r; v.exp_ill = ill;
    tbl.push_back(v);
  endtask

  task automatic add_fetch(input logic [63:0] name, input logic [31:0] i, input int stalls,
                           input logic ill, input logic stp2, input logic cf);
    add(name, 0, i, 1, cf, 0, F0, 4'd0, 1, 0);
    for (int k = 0; k < stalls; k++) add(name, 0, i, 0, cf, 0, F1, 4'd0, 1, 0);
    add(name, 0, i, 1, cf, 0, F1, 4'd0, 1, 0);
    add(name, 0, i, 1, cf, stp2, F2, 4'd0, 1, ill);
  endtask

  task automatic step(input logic r, input logic [31:0] i, input logic m, input logic c,
                      input logic s);
    @(negedge clock);
    reset = r; ir = i; mem_ready = m; con_ff = c; stop = s;
    #1;
  endtask

  task automatic check(input logic [63:0] name, input logic [19:0] es, input logic [3:0] ea,
                       input logic er, input logic ei);
    tests++;
    if (strobes !== es) begin
      fails++;
      $display("FAIL %0s strobes got %h want %h", name, strobes, es);
    end
    tests++;
    if (alu_op !== ea) begin
      fails++;
      $display("FAIL %0s alu_op got %b want %b", name, alu_op, ea);
    end
    tests++;
    if (run !== er) begin
      fails++;
      $display("FAIL %0s run got %b want %b", name, run, er);
    end
    tests++;
    if (illegal !== ei) begin
      fails++;
      $display("FAIL %0s illegal got %b want %b", name, illegal, ei);
    end
  endtask

  logic [31:0] alu_ir[4];
  logic [3:0]  alu_code[4];

  initial begin
    alu_ir[0] = 32'h19890000; alu_code[0] = 4'b0000;
    alu_ir[1] = 32'h20000000; alu_code[1] = 4'b0001;
    alu_ir[2] = 32'h28000000; alu_code[2] = 4'b0010;
    alu_ir[3] = 32'h30000000; alu_code[3] = 4'b0011;

    add("reset", 1, IR_LDI, 1, 0, 0, 20'h0, 4'd0, 1, 0);
    // ldi: T5 writes back, next fetch T0 at cycle 6
    add_fetch("ldi", IR_LDI, 0, 0, 0, 0);
    add("ldi_T3", 0, IR_LDI, 1, 0, 0, GRB | BAOUT | YIN, 4'd0, 1, 0);
    add("ldi_T4", 0, IR_LDI, 1, 0, 0, COUT | ZIN, 4'd0, 1, 0);
    add("ldi_T5", 0, IR_LDI, 1, 0, 0, ZLOW | GRA | RIN, 4'd0, 1, 0);
    // ALU ops; stop raised mid-instruction on the add must be ignored
    for (int k = 0; k < 4; k++) begin
      add_fetch("alu", alu_ir[k], 0, 0, 0, 0);
      add("alu_T3", 0, alu_ir[k], 1, 0, (k == 0), GRB | ROUT | YIN, 4'd0, 1, 0);
      add("alu_T4", 0, alu_ir[k], 1, 0, (k == 0), GRC | ROUT | ZIN, alu_code[k], 1, 0);
      add("alu_T5", 0, alu_ir[k], 1, 0, 0, ZLOW | GRA | RIN, 4'd0, 1, 0);
    end
    // ld with 3-cycle T1 stall and 2-cycle T6 stall
    add_fetch("ld", IR_LD, 3, 0, 0, 0);
    add("ld_T3", 0, IR_LD, 1, 0, 0, GRB | BAOUT | YIN, 4'd0, 1, 0);
    add("ld_T4", 0, IR_LD, 1, 0, 0, COUT | ZIN, 4'd0, 1, 0);
    add("ld_T5", 0, IR_LD, 1, 0, 0, ZLOW | MARIN, 4'd0, 1, 0);
    add("ld_T6w", 0, IR_LD, 0, 0, 1, READ | MDRIN, 4'd0, 1, 0);
    add("ld_T6w", 0, IR_LD, 0, 0, 0, READ | MDRIN, 4'd0, 1, 0);
    add("ld_T6", 0, IR_LD, 1, 0, 0, READ | MDRIN, 4'd0, 1, 0);
    add("ld_T7", 0, IR_LD, 1, 0, 0, MDROUT | GRA | RIN, 4'd0, 1, 0);
    // st with one T7 stall
    add_fetch("st", IR_ST, 0, 0, 0, 0);
    add("st_T3", 0, IR_ST, 1, 0, 0, GRB | BAOUT | YIN, 4'd0, 1, 0);
    add("st_T4", 0, IR_ST, 1, 0, 0, COUT | ZIN, 4'd0, 1, 0);
    add("st_T5", 0, IR_ST, 1, 0, 0, ZLOW | MARIN, 4'd0, 1, 0);
    add("st_T6", 0, IR_ST, 0, 0, 0, GRA | ROUT | MDRIN, 4'd0, 1, 0);
    add("st_T7w", 0, IR_ST, 0, 0, 0, WRITE, 4'd0, 1, 0);
    add("st_T7", 0, IR_ST, 1, 0, 0, WRITE, 4'd0, 1, 0);
    add_fetch("addi", IR_ADDI, 0, 0, 0, 0);
    add("addi_T3", 0, IR_ADDI, 1, 0, 0, GRB | ROUT | YIN, 4'd0, 1, 0);
    add("addi_T4", 0, IR_ADDI, 1, 0, 0, COUT | ZIN, 4'd0, 1, 0);
    add("addi_T5", 0, IR_ADDI, 1, 0, 0, ZLOW | GRA | RIN, 4'd0, 1, 0);
    for (int c = 0; c < 2; c++) begin
      add_fetch("br", IR_BR, 0, 0, 0, c[0]);
      add("br_T3", 0, IR_BR, 1, c[0], 0, GRA | ROUT | CONIN, 4'd0, 1, 0);
      add("br_T4", 0, IR_BR, 1, c[0], 0, PCOUT | YIN, 4'd0, 1, 0);
      add("br_T5", 0, IR_BR, 1, c[0], 0, COUT | ZIN, 4'd0, 1, 0);
      add("br_T6", 0, IR_BR, 1, c[0], 0, (c == 1) ? (ZLOW | PCIN) : 20'h0, 4'd0, 1, 0);
    end
    add_fetch("nop", IR_NOP, 0, 0, 0, 0);
    add_fetch("illegal", IR_BAD, 0, 1, 0, 0);
    // reset while ld sits in T5: reset cycle silent, then a fresh fetch
    add_fetch("ld_rst", IR_LD, 0, 0, 0, 0);
    add("ld_rT3", 0, IR_LD, 1, 0, 0, GRB | BAOUT | YIN, 4'd0, 1, 0);
    add("ld_rT4", 0, IR_LD, 1, 0, 0, COUT | ZIN, 4'd0, 1, 0);
    add("ld_rT5", 1, IR_LD, 1, 0, 0, 20'h0, 4'd0, 1, 0);
    // stop honoured at the end of a nop
    add_fetch("nop_stp", IR_NOP, 0, 0, 1, 0);
    add("stp_halt", 0, IR_NOP, 1, 0, 0, 20'h0, 4'd0, 0, 0);
    add("stp_rst", 1, IR_NOP, 1, 0, 0, 20'h0, 4'd0, 1, 0);
    add_fetch("halt", IR_HALT, 0, 0, 0, 0);

    for (int n = 0; n < tbl.size(); n++) begin
      step(tbl[n].rst, tbl[n].ir, tbl[n].mr, tbl[n].cf, tbl[n].stp);
      check(tbl[n].name, tbl[n].exp_s, tbl[n].exp_alu, tbl[n].exp_run, tbl[n].exp_ill);
    end

    // HALT is sticky: 20 quiet cycles regardless of stop/mem_ready/ir
    for (int n = 0; n < 20; n++) begin
      step(0, (n % 3 == 0) ? IR_LD : IR_HALT, n[0], n[1], n[2]);
      check("halted", 20'h0, 4'd0, 0, 0);
    end
    step(1, IR_LD, 1, 0, 0);
    check("hlt_rst", 20'h0, 4'd0, 1, 0);
    step(0, IR_LD, 1, 0, 0);
    check("rst_T0", F0, 4'd0, 1, 0);

    // reset during a T1 memory stall aborts the fetch
    step(0, IR_LD, 0, 0, 0);
    check("stall_T1", F1, 4'd0, 1, 0);
    step(0, IR_LD, 0, 0, 0);
    check("stall_T1", F1, 4'd0, 1, 0);
    step(1, IR_LD, 0, 0, 0);
    check("stall_rst", 20'h0, 4'd0, 1, 0);
    step(0, IR_LD, 0, 0, 0);
    check("abort_T0", F0, 4'd0, 1, 0);
    step(0, IR_LD, 1, 0, 0);
    check("abort_T1", F1, 4'd0, 1, 0);
    step(0, IR_LD, 1, 0, 0);
    check("abort_T2", F2, 4'd0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
